// File: rtl/dma_stream_ctl_pkg.sv
// Shared sizes and types for the GEMM stream-side DMA controller.
package dma_pkg;

    localparam int SRC_WORDS = 16;
    localparam int DST_WORDS = 8;
    localparam int SRC_AW    = 4;
    localparam int DST_AW    = 3;
    localparam int DW        = 64;

    localparam logic [SRC_AW-1:0] SRC_LAST = SRC_AW'(SRC_WORDS - 1);
    localparam logic [DST_AW-1:0] DST_LAST = DST_AW'(DST_WORDS - 1);

    typedef enum logic [1:0] {
        LOAD,
        RUN,
        WAIT,
        DRAIN
    } state_e;

    // One output-stream entry: result word plus its end-of-frame marker.
    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

endpackage

// File: rtl/dma_stream_ctl_skid_fifo2.sv
// Two-entry shift FIFO; the head entry sits in dedicated flops so the
// stream outputs it feeds come straight from registers.
module skid_fifo2
    import dma_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  beat_t      push_beat_i,
    input  logic       pop_i,
    output logic [1:0] count_o,
    output logic       head_valid_o,
    output beat_t      head_o
);

    beat_t head_q;
    beat_t tail_q;
    logic  head_v_q;
    logic  tail_v_q;

    // Pop is only raised with a valid head, and the read credit keeps push
    // from ever arriving while both entries are full and nothing leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the storage is reset too, because the head drives tdata/tlast
            // and those have defined reset values.
            head_q   <= '0;
            tail_q   <= '0;
            head_v_q <= 1'b0;
            tail_v_q <= 1'b0;
        end else if (pop_i) begin
            if (tail_v_q) begin
                head_q <= tail_q;
                if (push_i) begin
                    tail_q <= push_beat_i;
                end else begin
                    tail_v_q <= 1'b0;
                end
            end else if (push_i) begin
                head_q <= push_beat_i;
            end else begin
                head_v_q <= 1'b0;
            end
        end else if (push_i) begin
            if (!head_v_q) begin
                // NOTE: non-blocking assignments keep every flop in this block
                // sampling pre-edge values, independent of statement order.
                head_q   <= push_beat_i;
                head_v_q <= 1'b1;
            end else begin
                tail_q   <= push_beat_i;
                tail_v_q <= 1'b1;
            end
        end
    end

    assign count_o      = 2'(head_v_q) + 2'(tail_v_q);
    assign head_valid_o = head_v_q;
    assign head_o       = head_q;

endmodule

// File: rtl/dma_stream_ctl.sv
// Loads one 16-beat frame into the source buffer, kicks the compute core,
// then streams the 8 destination-buffer words back out.
module dma_stream_ctl
    import dma_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [DW-1:0]     s_axis_tdata,
    input  logic              s_axis_tlast,
    output logic              src_v,
    output logic [SRC_AW-1:0] src_a,
    output logic [DW-1:0]     src_d,
    output logic              run,
    input  logic              done,
    output logic              dst_v,
    output logic [DST_AW-1:0] dst_a,
    input  logic [DW-1:0]     dst_d,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DW-1:0]     m_axis_tdata,
    output logic              m_axis_tlast,
    output logic              err
);

    localparam logic [DST_AW:0] RD_END = (DST_AW + 1)'(DST_WORDS);

    state_e              state_q;
    logic [SRC_AW-1:0]   in_cnt_q;
    logic [DST_AW:0]     rd_cnt_q;
    logic                src_v_q;
    logic [SRC_AW-1:0]   src_a_q;
    logic [DW-1:0]       src_d_q;
    logic                run_q;
    logic                err_q;
    logic                rd_pend_q;
    logic                rd_pend_last_q;

    logic                fifo_pop;
    logic [1:0]          fifo_count;
    logic                head_valid;
    beat_t               head;
    beat_t               push_beat;
    logic [2:0]          occupancy;
    logic                credit;
    logic                rd_issue;

    // Held words plus the read still in flight must leave room after this
    // cycle's pop, so the FIFO can never be overrun.
    assign fifo_pop  = head_valid & m_axis_tready;
    assign occupancy = 3'(fifo_count) + 3'(rd_pend_q);
    assign credit    = occupancy < (3'd2 + 3'(fifo_pop));
    assign rd_issue  = (state_q == DRAIN) && (rd_cnt_q < RD_END) && credit;

    // Gated by rst_n so the port reads low while reset is held, even though
    // the state register already sits in LOAD.
    assign s_axis_tready = rst_n && (state_q == LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= LOAD;
            in_cnt_q       <= '0;
            rd_cnt_q       <= '0;
            src_v_q        <= 1'b0;
            src_a_q        <= '0;
            src_d_q        <= '0;
            run_q          <= 1'b0;
            err_q          <= 1'b0;
            rd_pend_q      <= 1'b0;
            rd_pend_last_q <= 1'b0;
        end else begin
            src_v_q        <= 1'b0;
            err_q          <= 1'b0;
            rd_pend_q      <= rd_issue;
            rd_pend_last_q <= rd_issue && (rd_cnt_q[DST_AW-1:0] == DST_LAST);

            case (state_q)
                LOAD: begin
                    if (s_axis_tvalid) begin
                        src_v_q <= 1'b1;
                        src_a_q <= in_cnt_q;
                        src_d_q <= s_axis_tdata;
                        if (in_cnt_q == SRC_LAST) begin
                            // A full frame is used even without its tlast.
                            err_q    <= !s_axis_tlast;
                            in_cnt_q <= '0;
                            state_q  <= RUN;
                        end else if (s_axis_tlast) begin
                            err_q    <= 1'b1;
                            in_cnt_q <= '0;
                        end else begin
                            in_cnt_q <= in_cnt_q + SRC_AW'(1);
                        end
                    end
                end
                RUN: begin
                    run_q <= !run_q;
                    if (run_q) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (done) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (rd_issue) begin
                        rd_cnt_q <= rd_cnt_q + (DST_AW + 1)'(1);
                    end
                    if (fifo_pop && head.last) begin
                        rd_cnt_q <= '0;
                        in_cnt_q <= '0;
                        state_q  <= LOAD;
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign push_beat = '{last: rd_pend_last_q, data: dst_d};

    skid_fifo2 u_out_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (rd_pend_q),
        .push_beat_i  (push_beat),
        .pop_i        (fifo_pop),
        .count_o      (fifo_count),
        .head_valid_o (head_valid),
        .head_o       (head)
    );

    assign src_v         = src_v_q;
    assign src_a         = src_a_q;
    assign src_d         = src_d_q;
    assign run           = run_q;
    assign err           = err_q;
    assign dst_v         = rd_issue;
    assign dst_a         = rd_cnt_q[DST_AW-1:0];
    assign m_axis_tvalid = head_valid;
    assign m_axis_tdata  = head.data;
    assign m_axis_tlast  = head.last;

endmodule

// File: tb/tb_dma_stream_ctl.sv
// Scoreboard bench for dma_stream_ctl: drivers push expected events into
// queues, a single negedge monitor pops and compares them.
module tb_dma_stream_ctl;
    import dma_pkg::*;

    typedef struct {
        logic [3:0]  addr;
        logic [63:0] data;
    } src_exp_t;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } out_exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [63:0] s_axis_tdata = '0;
    logic        s_axis_tlast = 1'b0;
    logic        src_v;
    logic [3:0]  src_a;
    logic [63:0] src_d;
    logic        run;
    logic        done = 1'b0;
    logic        dst_v;
    logic [2:0]  dst_a;
    logic [63:0] dst_d = '0;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    src_exp_t src_exp[$];
    int       run_exp[$];
    int       err_exp[$];
    out_exp_t out_exp[$];

    logic [63:0] dst_mem [8];
    int  in_idx = 0;
    int  rdy_mode = 0;
    int  exp_rd = 0;
    int  issued = 0;
    int  popped = 0;
    int  pops = 0;
    int  first_dst = -1;
    int  first_valid = -1;
    int  tlast_cyc = -1;
    bit  tlast_seen = 1'b0;
    bit  drain_armed = 1'b0;

    dma_stream_ctl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .src_v         (src_v),
        .src_a         (src_a),
        .src_d         (src_d),
        .run           (run),
        .done          (done),
        .dst_v         (dst_v),
        .dst_a         (dst_a),
        .dst_d         (dst_d),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .err           (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Destination buffer: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (dst_v) dst_d <= dst_mem[dst_a];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference rules for one accepted input beat.
    task automatic model_accept(input logic [63:0] d, input bit last, input int t);
        src_exp.push_back('{addr: 4'(in_idx), data: d});
        if (in_idx == SRC_WORDS - 1) begin
            run_exp.push_back(t + 2);
            if (!last) err_exp.push_back(t + 1);
            in_idx = 0;
        end else if (last) begin
            err_exp.push_back(t + 1);
            in_idx = 0;
        end else begin
            in_idx++;
        end
    endtask

    // Entered and left at posedge+1.
    task automatic send_frame(input int n, input int last_idx, input int gap, input bit seq,
                              output int t_last);
        logic [63:0] d;
        bit          acc;
        t_last = 0;
        for (int i = 0; i < n; i++) begin
            d = seq ? 64'(i) : {$urandom, $urandom};
            s_axis_tdata  = d;
            s_axis_tlast  = (i == last_idx);
            s_axis_tvalid = 1'b1;
            acc = 1'b0;
            for (int g = 0; g < 200 && !acc; g++) begin
                @(negedge clk);
                if (s_axis_tready) begin
                    acc    = 1'b1;
                    t_last = cyc;
                    model_accept(d, i == last_idx, cyc);
                end
                @(posedge clk);
                #1;
            end
            check("s_tready_timeout", 64'(acc), 64'd1);
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic issue_done(input int w, input bit expect_drain);
        while (cyc < w) begin
            @(posedge clk);
            #1;
        end
        if (expect_drain) begin
            for (int i = 0; i < DST_WORDS; i++) begin
                dst_mem[i] = {$urandom, $urandom};
                out_exp.push_back('{data: dst_mem[i], last: (i == DST_WORDS - 1)});
            end
            exp_rd = 0; issued = 0; popped = 0; pops = 0;
            first_dst = -1; first_valid = -1; tlast_cyc = -1; tlast_seen = 1'b0;
            drain_armed = 1'b1;
        end
        done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0;
    endtask

    task automatic wait_drain();
        for (int g = 0; g < 500 && !tlast_seen; g++) begin
            @(posedge clk);
            #1;
        end
        check("drain_complete", 64'(tlast_seen), 64'd1);
    endtask

    task automatic check_queues(input string tag);
        check({tag, "_src_left"}, 64'(src_exp.size()), 64'd0);
        check({tag, "_run_left"}, 64'(run_exp.size()), 64'd0);
        check({tag, "_err_left"}, 64'(err_exp.size()), 64'd0);
        check({tag, "_out_left"}, 64'(out_exp.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_tready"}, 64'(s_axis_tready), 64'd0);
        check({tag, "_src_v"},    64'(src_v), 64'd0);
        check({tag, "_src_a"},    64'(src_a), 64'd0);
        check({tag, "_src_d"},    src_d, 64'd0);
        check({tag, "_run"},      64'(run), 64'd0);
        check({tag, "_dst_v"},    64'(dst_v), 64'd0);
        check({tag, "_dst_a"},    64'(dst_a), 64'd0);
        check({tag, "_m_tvalid"}, 64'(m_axis_tvalid), 64'd0);
        check({tag, "_m_tdata"},  m_axis_tdata, 64'd0);
        check({tag, "_m_tlast"},  64'(m_axis_tlast), 64'd0);
        check({tag, "_err"},      64'(err), 64'd0);
    endtask

    task automatic full_cycle(input int gap, input int last_idx, input int done_delay,
                              input int mode, input bit seq, output int t, output int w);
        rdy_mode = mode;
        send_frame(SRC_WORDS, last_idx, gap, seq, t);
        w = t + 2 + done_delay;
        issue_done(w, 1'b1);
        wait_drain();
    endtask

    // m_axis_tready pattern generator.
    initial begin
        logic [5:0] pat;
        int         pat_i;
        pat   = 6'b101001;
        pat_i = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_axis_tready = 1'b1;
                1: begin
                    m_axis_tready = pat[pat_i];
                    pat_i = (pat_i + 1) % 6;
                end
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor / scoreboard.
    src_exp_t    se;
    out_exp_t    oe;
    int          rc;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_data;
    logic        prev_last;
    bit          pop_now;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            pop_now = m_axis_tvalid && m_axis_tready;
            if (src_v) begin
                if (src_exp.size() == 0) check("src_v_unexpected", 64'(src_v), 64'd0);
                else begin
                    se = src_exp.pop_front();
                    check("src_a", 64'(src_a), 64'(se.addr));
                    check("src_d", src_d, se.data);
                end
            end
            if (run) begin
                if (run_exp.size() == 0) check("run_unexpected", 64'(run), 64'd0);
                else begin
                    rc = run_exp.pop_front();
                    check("run_cycle", 64'(cyc), 64'(rc));
                end
            end
            if (err) begin
                if (err_exp.size() == 0) check("err_unexpected", 64'(err), 64'd0);
                else begin
                    rc = err_exp.pop_front();
                    check("err_cycle", 64'(cyc), 64'(rc));
                end
            end
            if (dst_v) begin
                if (!drain_armed) check("dst_v_unexpected", 64'(dst_v), 64'd0);
                else begin
                    check("dst_a", 64'(dst_a), 64'(exp_rd));
                    check("dst_credit", 64'((issued - popped) < 2 + int'(pop_now)), 64'd1);
                    if (first_dst < 0) first_dst = cyc;
                    exp_rd++;
                    issued++;
                end
            end
            if (prev_stall) begin
                check("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
                check("stall_tdata", m_axis_tdata, prev_data);
                check("stall_tlast", 64'(m_axis_tlast), 64'(prev_last));
            end
            if (m_axis_tvalid && first_valid < 0) first_valid = cyc;
            if (pop_now) begin
                if (out_exp.size() == 0) check("m_beat_unexpected", 64'(m_axis_tvalid), 64'd0);
                else begin
                    oe = out_exp.pop_front();
                    check("m_tdata", m_axis_tdata, oe.data);
                    check("m_tlast", 64'(m_axis_tlast), 64'(oe.last));
                end
                pops++;
                popped++;
                if (m_axis_tlast) begin
                    tlast_seen  = 1'b1;
                    tlast_cyc   = cyc;
                    drain_armed = 1'b0;
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int w;

        #2;
        check_reset_outputs("por");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("load_tready_after_reset", 64'(s_axis_tready), 64'd1);
        @(posedge clk);
        #1;

        // Sequential frame, done five cycles after run, sink always ready.
        full_cycle(0, 15, 5, 0, 1'b1, t, w);
        check("t1_first_dst_v", 64'(first_dst), 64'(w + 1));
        check("t1_first_tvalid", 64'(first_valid), 64'(w + 3));
        check("t1_tlast_cycle", 64'(tlast_cyc), 64'(w + 10));
        @(negedge clk);
        while (cyc < w + 11) @(negedge clk);
        check("t1_s_tready_back", 64'(s_axis_tready), 64'd1);
        @(posedge clk);
        #1;
        check_queues("t1");

        // tvalid every other cycle, missing tlast on beat 15, random sink.
        full_cycle(1, -1, 3, 2, 1'b0, t, w);
        check_queues("t2");

        // Early tlast on beat 5, then a full frame drained with the 1,0,0,1,0,1 sink.
        rdy_mode = 0;
        send_frame(6, 5, 0, 1'b0, t);
        full_cycle(0, 15, 2, 1, 1'b0, t, w);
        check_queues("t3");

        // Stray done in LOAD and in RUN must not start a drain.
        rdy_mode = 0;
        issue_done(cyc, 1'b0);
        send_frame(SRC_WORDS, 15, 0, 1'b0, t);
        issue_done(cyc, 1'b0);
        w = t + 12;
        issue_done(w, 1'b1);
        wait_drain();
        check("t5_first_dst_v", 64'(first_dst), 64'(w + 1));
        check_queues("t5");

        // Reset while output beat 3 is presented.
        rdy_mode = 0;
        send_frame(SRC_WORDS, 15, 0, 1'b0, t);
        issue_done(t + 4, 1'b1);
        for (int g = 0; g < 100 && pops < 3; g++) begin
            @(posedge clk);
            #1;
        end
        check("t6_beats_before_reset", 64'(pops), 64'd3);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid");
        src_exp.delete();
        run_exp.delete();
        err_exp.delete();
        out_exp.delete();
        in_idx = 0;
        drain_armed = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        full_cycle(0, 15, 4, 2, 1'b0, t, w);
        check_queues("t6");

        // A few fully random frames.
        for (int k = 0; k < 3; k++) begin
            full_cycle(int'($urandom_range(0, 1)), 15, int'($urandom_range(1, 6)), 2, 1'b0, t, w);
        end
        check_queues("rand");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dma_stream_ctl.md
# dma_stream_ctl

Stream-side controller for the GEMM source/destination buffers. It accepts one 16-beat, 64-bit AXI-Stream frame from the DMA and writes it into the source buffer. It then starts the compute core and waits for completion. Finally it reads the 8 result words out of the destination buffer and emits them as an 8-beat AXI-Stream frame back to the DMA.

## Interface
- SRC_WORDS, 16: beats per input frame; equals source buffer depth (src_a width 4)
- DST_WORDS, 8: beats per output frame; equals destination buffer depth (dst_a width 3)
- clk  in  1  single clock; all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- s_axis_tvalid / s_axis_tready  in / out  1 / 1  input stream handshake
- s_axis_tdata  in  64  input beat
- s_axis_tlast  in  1  input end-of-frame
- src_v  out  1  source buffer write strobe
- src_a  out  4  source buffer write address
- src_d  out  64  source buffer write data
- run  out  1  one-cycle start pulse to the compute core
- done  in  1  one-cycle completion pulse from the compute core
- dst_v  out  1  destination buffer read strobe; dst_d is valid the following cycle
- dst_a  out  3  destination buffer read address
- dst_d  in  64  destination buffer read data
- m_axis_tvalid / m_axis_tready  out / in  1 / 1  output stream handshake
- m_axis_tdata  out  64  output beat
- m_axis_tlast  out  1  high on beat DST_WORDS-1
- err  out  1  one-cycle pulse on input framing error

## Operation
- States: LOAD, RUN, WAIT, DRAIN.
- **LOAD**
  - s_axis_tready=1.
  - Each accepted beat is registered to src_v=1, src_a=in_cnt, src_d=tdata in the next cycle, and in_cnt increments.
  - Accepted tlast with in_cnt<15: err pulse, in_cnt←0, stay in LOAD; the partial frame is discarded and later overwritten.
  - Beat 15 accepted (in_cnt==15): go to RUN. A missing tlast on beat 15 raises err but the frame is still used.
- **RUN**
  - s_axis_tready=0.
  - run=1 for exactly one cycle, then go to WAIT.
- **WAIT**
  - Stay until done=1, then go to DRAIN.
  - done in any other state is ignored.
- **DRAIN**
  - Issue dst_v=1, dst_a=rd_cnt while rd_cnt<8 and credit is available (credit rule under Timing).
  - Returned dst_d is pushed into the 2-entry output FIFO. The FIFO head drives m_axis_*.
  - m_axis_tlast is set on the entry read from address 7.
  - Handshake of the tlast beat: rd_cnt←0, in_cnt←0, go to LOAD.
- Buffer access is never concurrent with the core:
  - src_v is never high after RUN is entered and before the next LOAD.
  - dst_v is only issued after done, so the core's result write port is idle.
- Reset values: s_axis_tready=0, src_v=0, src_a=0, src_d=0, run=0, dst_v=0, dst_a=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, err=0. State after reset is LOAD.
- Reset asserted mid-frame or mid-drain: counters, state and FIFO clear immediately, with no completion of the partial frame. A pending done is lost.

## Timing
- Input: beat 15 handshake at cycle T:
  - src_v/src_a=15 at T+1;
  - run=1 at T+2;
  - WAIT from T+3.
- done at cycle W: DRAIN first cycle W+1, with dst_v=1, dst_a=0 at W+1.
- Credit rule:
  - Issue a read when fifo_count + inflight − pop < 2.
  - pop = m_axis_tvalid & m_axis_tready.
  - inflight = dst_v of the previous cycle.
- With m_axis_tready held high:
  - m_axis_tvalid first at W+3;
  - 8 consecutive beats W+3..W+10;
  - tlast at W+10;
  - s_axis_tready=1 at W+11.
- m_axis_tready low: m_axis_tdata/tlast/tvalid hold stable, no read data is dropped, and at most 2 words are buffered.
- s_axis_tready and dst_v are combinational from state and counters. All other outputs are registered.

## Structure
- Package dma_pkg holds:
  - state enum (LOAD, RUN, WAIT, DRAIN);
  - SRC_WORDS, DST_WORDS;
  - SRC_AW=4, DST_AW=3, DW=64.
- Sub-module skid_fifo2: 2-entry, 65-bit (data+last) FIFO with push/pop, count, and head outputs.

## Test plan
- Frame 0x0..0xF (tlast on beat 15), then done 5 cycles after run → src writes addr 0..15 with matching data, run exactly once at T+2, output beats = dst_buf contents 0..7 with tlast only on beat 7, s_axis_tready high at W+11.
- Input with tvalid toggling every other cycle → src_a still sequential 0..15, one run pulse.
- tlast on beat 5 → err pulse, no run, next full 16-beat frame loads from src_a=0.
- m_axis_tready pattern 1,0,0,1,0,1… during DRAIN → all 8 words delivered in order, none duplicated, tvalid/tdata stable while stalled, dst_v never issued with 2 words already held.
- done pulsed during LOAD and during RUN → ignored; DRAIN starts only on done in WAIT.
- rst_n low at output beat 3 → all outputs at reset values asynchronously; after release, a new frame runs normally from src_a=0 and dst_a=0.
